avalon_burst_arbiter: RTL
=========================

AVALON_BURST_ARBITER -- requirements
Module: avalon_burst_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width for both hosts and the shared SDRAM port.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter BURST_W, default 6, burstcount width.
REQ-004 The port list SHALL be, one per line, name direction width meaning:
- sys_clk  in  1  single clock, shared by the hosts and the SDRAM port.
- sys_rst_n  in  1  synchronous, active-low reset.
- hN_address  in  ADDR_W  host N byte address (N = 0 video reader, N = 1 general host).
- hN_read / hN_write  in  1  host N read and write requests.
- hN_burstcount  in  BURST_W  host N burst length in beats.
- hN_byteenable  in  DATA_W/8  host N byte enables.
- hN_writedata  in  DATA_W  host N write data.
- hN_waitrequest  out  1  host N stall.
- hN_readdata  out  DATA_W  read data to host N.
- hN_readdatavalid  out  1  read beat valid to host N.
- s_address, s_read, s_write, s_burstcount, s_byteenable, s_writedata  out  as the host ports  shared SDRAM command.
- s_waitrequest, s_readdata, s_readdatavalid  in  1/DATA_W/1  SDRAM response.

Function
REQ-005 The block SHALL grant the single SDRAM port to one host at a time and hold the grant for the whole burst.
REQ-006 The FSM SHALL have these states: IDLE, CMD, RDATA, WDATA.
REQ-007 IDLE: if any hN_read or hN_write is high at the sys_clk edge, the block SHALL latch the owner and a beat counter equal to that host's burstcount, then go to CMD; burstcount 0 SHALL be treated as 1.
REQ-008 In IDLE: s_read = s_write = 0 and both hN_waitrequest = 1.
REQ-009 CMD: all s_* command outputs SHALL combinationally mirror the owner's inputs, the owner's hN_waitrequest = s_waitrequest, and the non-owner's hN_waitrequest = 1.
REQ-010 CMD, read accepted (owner read high and s_waitrequest low): the FSM SHALL go to RDATA.
REQ-011 CMD, write accepted: the beat counter SHALL decrement; at a count of 1 the FSM SHALL go to IDLE, otherwise to WDATA.
REQ-012 WDATA: commands SHALL be forwarded as in CMD, the counter SHALL decrement on each accepted write beat, and the FSM SHALL go to IDLE after the final beat.
REQ-013 RDATA: s_read = s_write = 0, both hosts stalled, and the counter SHALL decrement on each s_readdatavalid; the FSM SHALL go to IDLE on the final beat.
REQ-014 hN_readdata SHALL be s_readdata broadcast to both hosts; hN_readdatavalid SHALL be asserted only for the owner and only in RDATA.
REQ-015 Latency: a request sampled in IDLE at edge k SHALL be driven on s_* during cycle k+1; one IDLE cycle SHALL separate consecutive bursts.
REQ-016 s_readdatavalid seen outside RDATA SHALL be dropped and SHALL NOT alter the counter.
REQ-017 A simultaneous request from the non-owner SHALL wait; it SHALL NOT preempt the owner.
REQ-018 Default arbitration SHALL be round-robin: when both hosts request in IDLE, grant goes to the host that is not last_owner; last_owner updates on each grant.

Reset
REQ-019 With sys_rst_n low at a sys_clk edge, the block SHALL enter IDLE, clear the counter, and set last_owner = 1 so host 0 wins the first tie.
REQ-020 Reset asserted mid-burst SHALL abandon the burst; s_read and s_write SHALL be 0 and both waitrequests 1 from the next cycle.

Configuration
REQ-021 With ARB_FIXED_PRIO_EN defined, host 0 SHALL always win a tie and last_owner SHALL be unused.
REQ-022 Without ARB_FIXED_PRIO_EN, the round-robin of REQ-018 SHALL apply.

Structure
REQ-023 Package avalon_arb_pkg SHALL hold the arb_state_t enum (IDLE, CMD, RDATA, WDATA), the host_id_t typedef, and the NB_HOSTS = 2 constant.
REQ-024 Tie-break logic SHALL live in one sub-module, rr_arbiter (request vector and last_owner in, one-hot grant out, ARB_FIXED_PRIO_EN-aware).

Verification
REQ-025 h0 reads address 0x0, burst 16, s_waitrequest low: s_read is high in exactly 1 cycle, 16 h0_readdatavalid pulses, h1_readdatavalid stays 0, then IDLE.
REQ-026 h0 and h1 both issue 16-beat reads repeatedly, round-robin build: grant order is h0, h1, h0, h1, and neither host starves.
REQ-027 Same stimulus as REQ-026 with ARB_FIXED_PRIO_EN defined: h0 wins every tie; h1 is granted only when h0 is idle.
REQ-028 h1 writes burst 4 with s_waitrequest high for 3 cycles on beat 2: exactly 4 accepted beats reach s_*, and h0_waitrequest stays 1 throughout.
REQ-029 sys_rst_n low after 8 of 16 read beats: IDLE on the next cycle, s_read = 0, and the next h0 request is granted normally.
REQ-030 Stray s_readdatavalid in IDLE, and a request with burstcount 0: no hN_readdatavalid for the stray beat; the burstcount-0 request completes as 1 beat.

Source files
------------

// File: rtl/avalon_arb_pkg.sv
// Shared types for the two-host Avalon burst arbiter: FSM states, host id, host count.
package avalon_arb_pkg;

  localparam int NB_HOSTS = 2;

  typedef logic [$clog2(NB_HOSTS)-1:0] host_id_t;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RDATA,
    WDATA
  } arb_state_t;

  // Lowest set bit wins; grant vectors are one-hot so this is just an encoder.
  function automatic host_id_t onehot_to_id(input logic [NB_HOSTS-1:0] oh);
    host_id_t id;
    id = '0;
    for (int i = NB_HOSTS - 1; i >= 0; i--) begin
      if (oh[i]) id = host_id_t'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Two-host tie-break: round-robin on last_owner, or fixed host-0 priority when
// ARB_FIXED_PRIO_EN is defined.
module rr_arbiter
  import avalon_arb_pkg::*;
(
  input  logic [NB_HOSTS-1:0] req,
  input  host_id_t            last_owner,
  output logic [NB_HOSTS-1:0] grant
);

`ifdef ARB_FIXED_PRIO_EN
  logic unused_last_owner;
  assign unused_last_owner = ^last_owner;

  always_comb begin
    grant = '0;
    if (req[0]) grant[0] = 1'b1;
    else if (req[1]) grant[1] = 1'b1;
  end
`else
  // On a tie the host that did not own the previous burst goes next.
  always_comb begin
    grant = '0;
    if (&req) begin
      if (last_owner == host_id_t'(0)) grant[1] = 1'b1;
      else grant[0] = 1'b1;
    end else begin
      grant = req;
    end
  end
`endif

endmodule

// File: rtl/avalon_burst_arbiter.sv
// Shares one Avalon-MM SDRAM port between a video reader (h0) and a general host (h1),
// holding the grant for a whole burst. Define ARB_FIXED_PRIO_EN for fixed host-0 priority.
module avalon_burst_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 6
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,

  input  logic [ADDR_W-1:0]   h0_address,
  input  logic                h0_read,
  input  logic                h0_write,
  input  logic [BURST_W-1:0]  h0_burstcount,
  input  logic [DATA_W/8-1:0] h0_byteenable,
  input  logic [DATA_W-1:0]   h0_writedata,
  output logic                h0_waitrequest,
  output logic [DATA_W-1:0]   h0_readdata,
  output logic                h0_readdatavalid,

  input  logic [ADDR_W-1:0]   h1_address,
  input  logic                h1_read,
  input  logic                h1_write,
  input  logic [BURST_W-1:0]  h1_burstcount,
  input  logic [DATA_W/8-1:0] h1_byteenable,
  input  logic [DATA_W-1:0]   h1_writedata,
  output logic                h1_waitrequest,
  output logic [DATA_W-1:0]   h1_readdata,
  output logic                h1_readdatavalid,

  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [BURST_W-1:0]  s_burstcount,
  output logic [DATA_W/8-1:0] s_byteenable,
  output logic [DATA_W-1:0]   s_writedata,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_readdatavalid
);

  arb_state_t           state;
  host_id_t             owner;
  host_id_t             last_owner;
  logic [BURST_W-1:0]   beat_cnt;

  logic [NB_HOSTS-1:0]  req;
  logic [NB_HOSTS-1:0]  grant;
  host_id_t             grant_id;
  logic [BURST_W-1:0]   grant_burst;

  logic                 own_read;
  logic                 own_write;
  logic [ADDR_W-1:0]    own_address;
  logic [BURST_W-1:0]   own_burstcount;
  logic [DATA_W/8-1:0]  own_byteenable;
  logic [DATA_W-1:0]    own_writedata;

  logic                 fwd;
  logic                 last_beat;

  assign req = {h1_read | h1_write, h0_read | h0_write};

  rr_arbiter u_rr_arbiter (
    .req        (req),
    .last_owner (last_owner),
    .grant      (grant)
  );

  assign grant_id    = onehot_to_id(grant);
  assign grant_burst = (grant_id == host_id_t'(0)) ? h0_burstcount : h1_burstcount;

  always_comb begin
    own_read       = h0_read;
    own_write      = h0_write;
    own_address    = h0_address;
    own_burstcount = h0_burstcount;
    own_byteenable = h0_byteenable;
    own_writedata  = h0_writedata;
    if (owner != host_id_t'(0)) begin
      own_read       = h1_read;
      own_write      = h1_write;
      own_address    = h1_address;
      own_burstcount = h1_burstcount;
      own_byteenable = h1_byteenable;
      own_writedata  = h1_writedata;
    end
  end

  // Commands pass straight through only while the owner is in its command phase.
  assign fwd          = (state == CMD) || (state == WDATA);
  assign s_read       = fwd & own_read;
  assign s_write      = fwd & own_write;
  assign s_address    = own_address;
  assign s_burstcount = own_burstcount;
  assign s_byteenable = own_byteenable;
  assign s_writedata  = own_writedata;

  assign h0_waitrequest = (fwd && owner == host_id_t'(0)) ? s_waitrequest : 1'b1;
  assign h1_waitrequest = (fwd && owner == host_id_t'(1)) ? s_waitrequest : 1'b1;

  assign h0_readdata = s_readdata;
  assign h1_readdata = s_readdata;
  assign h0_readdatavalid = (state == RDATA) && (owner == host_id_t'(0)) && s_readdatavalid;
  assign h1_readdatavalid = (state == RDATA) && (owner == host_id_t'(1)) && s_readdatavalid;

  assign last_beat = (beat_cnt == BURST_W'(1));

  // Burst FSM; a zero burstcount is loaded as one beat so the counter always terminates.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= host_id_t'(1);
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            owner      <= grant_id;
            last_owner <= grant_id;
            beat_cnt   <= (grant_burst == '0) ? BURST_W'(1) : grant_burst;
            state      <= CMD;
          end
        end
        CMD: begin
          if (own_read && !s_waitrequest) begin
            state <= RDATA;
          end else if (own_write && !s_waitrequest) begin
            beat_cnt <= beat_cnt - BURST_W'(1);
            state    <= last_beat ? IDLE : WDATA;
          end
        end
        WDATA: begin
          if (own_write && !s_waitrequest) begin
            beat_cnt <= beat_cnt - BURST_W'(1);
            if (last_beat) state <= IDLE;
          end
        end
        RDATA: begin
          if (s_readdatavalid) begin
            beat_cnt <= beat_cnt - BURST_W'(1);
            if (last_beat) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
